// File: rtl/link_scheduler.sv
// rtl/link_scheduler.sv - round-robin output-link scheduler over VC_NUM local VC buffers
// Per-VC packet FSM, downstream on/off + allocatability gating, one flit per cycle to the link.
package noc_params;
  localparam int VC_NUM  = 4;
  localparam int VC_BITS = $clog2(VC_NUM);
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_BITS-1:0]   vc_id;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;
endpackage

module link_scheduler
  import noc_params::*;
#(
  parameter int VC_NUM = noc_params::VC_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             req_flit_i [VC_NUM],
  input  logic [VC_NUM-1:0] req_valid_i,
  output logic [VC_NUM-1:0] grant_o,
  output flit_t             data_o,
  output logic              valid_flit_o,
  input  logic [VC_NUM-1:0] on_off_i,
  input  logic [VC_NUM-1:0] is_allocatable_i,
  output logic [VC_NUM-1:0] vc_active_o,
  output logic              error_o
);
  localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  vc_state_t         vc_state_q [VC_NUM];
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  flit_t             data_q, data_d;
  logic              valid_q;
  logic              error_q, error_d;

  logic [VC_NUM-1:0] eligible;
  logic [VC_NUM-1:0] violation;
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  int                cand;

  // A head-type flit is legal only on an IDLE VC; body/tail only on an ACTIVE one.
  always_comb begin
    eligible  = '0;
    violation = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      logic is_head;
      is_head = (req_flit_i[v].flit_label == HEAD) || (req_flit_i[v].flit_label == HEADTAIL);
      if (req_valid_i[v]) begin
        if (vc_state_q[v] == ACTIVE) begin
          eligible[v]  = on_off_i[v] && !is_head;
          violation[v] = is_head;
        end else begin
          eligible[v]  = on_off_i[v] && is_head && is_allocatable_i[v];
          violation[v] = !is_head;
        end
      end
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      cand = (int'(rr_ptr_q) + i) % VC_NUM;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (grant_found && !rst) grant_o[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    error_d  = error_q | (|violation);
    if (grant_found) begin
      rr_ptr_d     = (int'(grant_idx) == VC_NUM - 1) ? '0 : grant_idx + 1'b1;
      data_d       = req_flit_i[grant_idx];
      data_d.vc_id = VC_BITS'(grant_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) vc_state_q[v] <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      valid_q  <= grant_found;
      error_q  <= error_d;
      if (grant_found) begin
        if (req_flit_i[grant_idx].flit_label == HEAD) vc_state_q[grant_idx] <= ACTIVE;
        if (req_flit_i[grant_idx].flit_label == TAIL) vc_state_q[grant_idx] <= IDLE;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) vc_active_o[v] = (vc_state_q[v] == ACTIVE);
  end

  assign data_o       = data_q;
  assign valid_flit_o = valid_q;
  assign error_o      = error_q;
endmodule

// File: tb/tb_link_scheduler.sv
// tb/tb_link_scheduler.sv - directed and randomized checks of link_scheduler against a packet-level model
module tb_link_scheduler;
  import noc_params::*;
  localparam int VC = 4;

  logic          clk = 1'b0;
  logic          rst;
  flit_t         req_flit [VC];
  logic [VC-1:0] req_valid, on_off, alloc;
  logic [VC-1:0] grant_o, vc_active_o;
  flit_t         data_o;
  logic          valid_flit_o, error_o;

  link_scheduler #(.VC_NUM(VC)) dut (
    .clk(clk), .rst(rst), .req_flit_i(req_flit), .req_valid_i(req_valid),
    .grant_o(grant_o), .data_o(data_o), .valid_flit_o(valid_flit_o),
    .on_off_i(on_off), .is_allocatable_i(alloc),
    .vc_active_o(vc_active_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // Model state: which VCs are mid-packet, pointer, last link word, sticky error.
  bit            m_active [VC];
  int            m_ptr;
  flit_t         m_data;
  bit            m_valid, m_err;
  logic [VC-1:0] last_grant;
  int            n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < VC; k++) begin
      int v = (m_ptr + k) % VC;
      if (req_valid[v] && on_off[v] &&
          (m_active[v] ? !is_head(req_flit[v].flit_label)
                       : (is_head(req_flit[v].flit_label) && alloc[v])))
        return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VC; v++) m_active[v] = 1'b0;
    m_ptr = 0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_regs();
    chk("valid_flit", valid_flit_o, m_valid);
    chk("data", data_o, m_data);
    chk("vc_active", vc_active_o, {m_active[3], m_active[2], m_active[1], m_active[0]});
    chk("error", error_o, m_err);
  endtask

  // Inputs are already applied; check grant, advance model, clock, check registered outputs.
  task automatic cycle();
    int p;
    logic [VC-1:0] eg;
    #1;
    p  = model_pick();
    eg = (p >= 0) ? (VC'(1) << p) : '0;
    chk("grant", grant_o, eg);
    last_grant = grant_o;
    for (int v = 0; v < VC; v++)
      if (req_valid[v] && (m_active[v] == is_head(req_flit[v].flit_label))) m_err = 1'b1;
    if (p >= 0) begin
      m_data       = req_flit[p];
      m_data.vc_id = VC_BITS'(p);
      m_valid      = 1'b1;
      m_ptr        = (p + 1) % VC;
      if (req_flit[p].flit_label == HEAD) m_active[p] = 1'b1;
      if (req_flit[p].flit_label == TAIL) m_active[p] = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic set_all(input logic [VC-1:0] vmask, input flit_label_t l);
    for (int v = 0; v < VC; v++) begin
      req_flit[v].flit_label = l;
      req_flit[v].vc_id      = VC_BITS'($urandom_range(VC - 1));
      req_flit[v].payload    = PAYLOAD_W'($urandom);
    end
    req_valid = vmask;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("grant_in_rst", grant_o, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_regs();
  endtask

  logic [VC-1:0] seq_a [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [VC-1:0] seq_b [6] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [VC-1:0] seq_c [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  flit_label_t   pkt   [4] = '{HEAD, BODY, BODY, TAIL};

  initial begin
    rst = 1'b1; req_valid = '0; on_off = '1; alloc = '1;
    set_all('0, HEAD);
    model_reset();
    @(posedge clk); #1;
    chk("reset_valid", valid_flit_o, 1'b0);
    chk("reset_active", vc_active_o, '0);
    chk("reset_error", error_o, 1'b0);
    do_reset();

    // Single packet on VC0.
    for (int i = 0; i < 4; i++) begin
      set_all(4'b0001, pkt[i]);
      cycle();
      chk("single_grant", last_grant, 4'b0001);
      chk("single_valid", valid_flit_o, 1'b1);
      chk("single_active", vc_active_o, (i < 3) ? 4'b0001 : 4'b0000);
    end

    // Open packets on every VC, then round-robin the bodies (pointer is at 1 now).
    set_all(4'b1111, HEAD);
    for (int i = 0; i < 4; i++) cycle();
    chk("all_active", vc_active_o, 4'b1111);
    set_all(4'b1111, BODY);
    for (int i = 0; i < 8; i++) begin cycle(); chk("rr_all", last_grant, seq_a[i]); end
    set_all(4'b1011, BODY);
    for (int i = 0; i < 6; i++) begin cycle(); chk("rr_skip2", last_grant, seq_b[i]); end

    // VC1 throttled for three cycles, then resumes.
    set_all(4'b1111, BODY);
    on_off = 4'b1101;
    for (int i = 0; i < 3; i++) begin cycle(); chk("onoff_block", last_grant, seq_c[i]); end
    on_off = 4'b1111;
    cycle(); chk("onoff_resume", last_grant, seq_c[3]);

    // Close all packets, then HEAD on VC2 gated by allocatability.
    set_all(4'b1111, TAIL);
    for (int i = 0; i < 4; i++) cycle();
    chk("all_idle", vc_active_o, 4'b0000);
    set_all(4'b0100, HEAD);
    alloc = 4'b1011;
    cycle(); chk("alloc_block", last_grant, 4'b0000);
    alloc = 4'b1111;
    cycle(); chk("alloc_grant", last_grant, 4'b0100);
    chk("alloc_vcid", data_o.vc_id, 2);
    chk("alloc_valid", valid_flit_o, 1'b1);

    // BODY on idle VC3 is a violation; HEADTAIL on VC0 passes and leaves it idle.
    set_all(4'b1000, BODY);
    cycle(); chk("err_nogrant", last_grant, 4'b0000);
    chk("err_set", error_o, 1'b1);
    set_all(4'b0001, HEADTAIL);
    cycle(); chk("ht_grant", last_grant, 4'b0001);
    chk("ht_idle", vc_active_o[0], 1'b0);
    chk("err_held", error_o, 1'b1);

    // Randomized traffic, mostly legal labels with occasional violations.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int v = 0; v < VC; v++) begin
        int r = $urandom_range(15);
        if (r == 0) req_flit[v].flit_label = flit_label_t'($urandom_range(3));
        else if (m_active[v]) req_flit[v].flit_label = (r < 12) ? BODY : TAIL;
        else req_flit[v].flit_label = (r < 10) ? HEAD : HEADTAIL;
        req_flit[v].vc_id   = VC_BITS'($urandom_range(VC - 1));
        req_flit[v].payload = PAYLOAD_W'($urandom);
        req_valid[v] = ($urandom_range(3) != 0);
        on_off[v]    = ($urandom_range(3) != 0);
        alloc[v]     = ($urandom_range(3) != 0);
      end
      cycle();
    end

    // Reset mid-packet on VC1 with a flit on the link.
    do_reset();
    on_off = '1; alloc = '1;
    set_all(4'b0010, HEAD); cycle();
    set_all(4'b0010, BODY); cycle();
    chk("mid_valid", valid_flit_o, 1'b1);
    chk("mid_active", vc_active_o, 4'b0010);
    rst = 1'b1;
    #1;
    chk("rst_valid", valid_flit_o, 1'b0);
    chk("rst_active", vc_active_o, 4'b0000);
    chk("rst_grant", grant_o, 4'b0000);
    @(posedge clk); #1;
    chk("rst_grant_hold", grant_o, 4'b0000);
    rst = 1'b0;
    model_reset();
    set_all(4'b0010, HEAD);
    cycle(); chk("post_rst_grant", last_grant, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
